// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: MIPS opcode constants, the table
// initialisation FSM states and the saturating counter update.
package bp_pkg;

    localparam logic [5:0] OP_BZ   = 6'd1;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_BLEZ = 6'd6;
    localparam logic [5:0] OP_BGTZ = 6'd7;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_t;

    // Counters are at most 4 bits wide; cnt_w selects the live width so one
    // function serves every CNT_W in 2..4.
    function automatic logic [3:0] sat_update(input logic [3:0] cnt,
                                              input logic       taken,
                                              input int         cnt_w);
        logic [3:0] max_val;
        max_val = 4'((5'd1 << cnt_w) - 5'd1);
        if (taken)
            return (cnt == max_val) ? cnt : cnt + 4'd1;
        else
            return (cnt == 4'd0) ? cnt : cnt - 4'd1;
    endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// Fetch-side prediction and resolve-side training signals of bht_predictor.
// The pipeline drives it through the master modport, the predictor is the slave.
interface bht_predictor_if #(
    parameter int IDX_W = 6
);
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_instr;
    logic             takebr;
    logic             takej;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             ready;

    modport master (
        output fetch_pc, fetch_instr, upd_valid, upd_idx, upd_taken,
        input  takebr, takej, pred_idx, ready
    );

    modport slave (
        input  fetch_pc, fetch_instr, upd_valid, upd_idx, upd_taken,
        output takebr, takej, pred_idx, ready
    );
endinterface

// File: rtl/bp_opdecode.sv
// Opcode classifier: conditional branch vs J/JAL. Opcode 0 (JR/JALR and
// ALU ops) is neither, so register jumps are never predicted.
module bp_opdecode
    import bp_pkg::*;
(
    input  logic [31:0] instr,
    output logic        isbranch,
    output logic        isjump
);
    logic [5:0] opcode;
    logic       unused_instr_bits;

    assign opcode            = instr[31:26];
    assign unused_instr_bits = ^instr[25:0];

    assign isbranch = (opcode == OP_BZ)  || (opcode == OP_BEQ)  ||
                      (opcode == OP_BNE) || (opcode == OP_BLEZ) ||
                      (opcode == OP_BGTZ);
    assign isjump   = (opcode == OP_J) || (opcode == OP_JAL);
endmodule

// File: rtl/bht_predictor.sv
// Branch history table predictor: per-index saturating counters, walked to
// weakly not-taken after reset, trained from the resolve stage.
// Optional feature macro: BHT_GSHARE_EN (XOR a global history into the
// fetch index).
module bht_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CNT_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    bht_predictor_if.slave bus
);
    localparam int              DEPTH    = 1 << IDX_W;
    localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'((1 << (CNT_W - 1)) - 1);

    bp_state_t        state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic [CNT_W-1:0] table_q [DEPTH];

    logic             isbranch, isjump;
    logic             ready, upd_fire;
    logic [IDX_W-1:0] pc_idx, pred_idx;
    logic [CNT_W-1:0] upd_next;
    logic             unused_pc_bits;

    bp_opdecode u_opdecode (
        .instr    (bus.fetch_instr),
        .isbranch (isbranch),
        .isjump   (isjump)
    );

    assign ready          = (state_q == RUN);
    assign upd_fire       = ready & bus.upd_valid;
    assign pc_idx         = bus.fetch_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{bus.fetch_pc[31:IDX_W+2], bus.fetch_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] history_q;

    // Global outcome history, shifted once per accepted training update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            history_q <= '0;
        else if (upd_fire)
            history_q <= {history_q[IDX_W-2:0], bus.upd_taken};
    end

    assign pred_idx = pc_idx ^ history_q;
`else
    assign pred_idx = pc_idx;
`endif

    // FSM and init-walk registers.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Next-state: INIT walks every entry once, then RUN holds until reset.
    // NOTE: hold values are assigned first so no path leaves an output unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == IDX_W'(DEPTH - 1))
                    state_d = RUN;
            end
            RUN: ;
        endcase
    end

    assign upd_next = CNT_W'(sat_update(4'(table_q[bus.upd_idx]), bus.upd_taken, CNT_W));

    // Table writes: init fill during INIT, at most one training update in RUN.
    // NOTE: the counter array has no reset; the INIT walk overwrites every entry instead.
    always_ff @(posedge clk) begin
        if (state_q == INIT)
            table_q[init_idx_q] <= INIT_VAL;
        else if (upd_fire)
            table_q[bus.upd_idx] <= upd_next;
    end

    assign bus.ready    = ready;
    assign bus.pred_idx = pred_idx;
    assign bus.takej    = isjump;
    assign bus.takebr   = ready & isbranch & table_q[pred_idx][CNT_W-1];
endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed scenarios plus random
// traffic compared against an array-of-integers reference model.
module tb_bht_predictor;
    localparam int IDX_W   = 6;
    localparam int CNT_W   = 2;
    localparam int DEPTH   = 1 << IDX_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int HALF    = 1 << (CNT_W - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    bht_predictor_if #(.IDX_W(IDX_W)) bus ();

    bht_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_cnt [DEPTH];
    bit m_ready;
    int m_init_cycles;
    int m_hist;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_index(input logic [31:0] pc);
        int idx;
        idx = int'((pc / 4) % DEPTH);
`ifdef BHT_GSHARE_EN
        idx = idx ^ m_hist;
`endif
        return idx;
    endfunction

    function automatic bit is_branch(input int op);
        return (op == 1) || (op >= 4 && op <= 7);
    endfunction

    function automatic bit is_jump(input int op);
        return (op == 2) || (op == 3);
    endfunction

    function automatic logic [31:0] mk_instr(input int op);
        logic [25:0] low;
        low = 26'($urandom);
        return {6'(op), low};
    endfunction

    // One clock cycle: called at a negedge, drives inputs, checks outputs
    // against the model, then advances the model across the posedge.
    task automatic cycle(input logic [31:0] pc, input logic [31:0] instr,
                         input bit uv, input int ui, input bit ut, input string tag);
        int op, idx;
        bus.fetch_pc    = pc;
        bus.fetch_instr = instr;
        bus.upd_valid   = uv;
        bus.upd_idx     = IDX_W'(ui);
        bus.upd_taken   = ut;
        #1;
        op  = int'(instr[31:26]);
        idx = m_index(pc);
        check({tag, " ready"},    32'(bus.ready),    32'(m_ready));
        check({tag, " takej"},    32'(bus.takej),    32'(is_jump(op)));
        check({tag, " takebr"},   32'(bus.takebr),
              32'(m_ready && is_branch(op) && (m_cnt[idx] >= HALF)));
        check({tag, " pred_idx"}, 32'(bus.pred_idx), 32'(idx));
        @(posedge clk);
        if (m_ready) begin
            if (uv) begin
                if (ut) m_cnt[ui] = (m_cnt[ui] < CNT_MAX) ? m_cnt[ui] + 1 : CNT_MAX;
                else    m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
                m_hist = ((m_hist << 1) | int'(ut)) % DEPTH;
            end
        end else begin
            m_init_cycles++;
            if (m_init_cycles == DEPTH) begin
                m_ready = 1'b1;
                foreach (m_cnt[i]) m_cnt[i] = HALF - 1;
            end
        end
        @(negedge clk);
    endtask

    // Asserts reset at a negedge (checking ready falls immediately), holds it
    // for two edges and releases it at a negedge.
    task automatic do_reset(input string tag);
        rst             = 1'b1;
        bus.upd_valid   = 1'b0;
        bus.fetch_pc    = 32'h0;
        bus.fetch_instr = mk_instr(4);
        #1;
        check({tag, " ready low"},  32'(bus.ready),  32'd0);
        check({tag, " takebr low"}, 32'(bus.takebr), 32'd0);
        m_ready       = 1'b0;
        m_init_cycles = 0;
        m_hist        = 0;
        foreach (m_cnt[i]) m_cnt[i] = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] jr_instr;
    int          ops [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 35, 43};

    initial begin
        jr_instr        = {6'd0, 5'd31, 15'd0, 6'd8};
        bus.fetch_pc    = '0;
        bus.fetch_instr = '0;
        bus.upd_valid   = 1'b0;
        bus.upd_idx     = '0;
        bus.upd_taken   = 1'b0;
        @(negedge clk);
        do_reset("por");

        // INIT: JAL predicted as jump, branches not, updates dropped.
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0)          cycle(32'h40, mk_instr(3), 1'b1, 3, 1'b1, "init_jal");
            else if (i % 3 == 1) cycle(32'h0C, mk_instr(4), 1'b1, 3, 1'b1, "init_beq");
            else                 cycle(32'($urandom), jr_instr, 1'b1, 0, 1'b1, "init_jr");
        end

        // RUN: fresh entries are weakly not-taken, including trained-during-INIT idx 3.
        cycle(32'h100, mk_instr(4), 1'b0, 0, 1'b0, "run_idx0");
        cycle(32'h00C, mk_instr(4), 1'b0, 0, 1'b0, "run_idx3");

        // idx 0 trained up, same-cycle fetch sees the old value; saturation at max.
        cycle(32'h100, mk_instr(4), 1'b1, 0, 1'b1, "up0_a");
        cycle(32'h100, mk_instr(4), 1'b1, 0, 1'b1, "up0_b");
        cycle(32'h100, mk_instr(4), 1'b1, 0, 1'b1, "up0_sat");
        cycle(32'h100, mk_instr(4), 1'b1, 0, 1'b0, "up0_hold");
        cycle(32'h100, mk_instr(4), 1'b0, 0, 1'b0, "up0_after");

        // idx 5 trained to 3, then four not-taken updates down to 0 and hold.
        for (int i = 0; i < 3; i++) cycle(32'h14, mk_instr(5), 1'b1, 5, 1'b1, "up5");
        for (int i = 0; i < 4; i++) cycle(32'h14, mk_instr(5), 1'b1, 5, 1'b0, "dn5");
        cycle(32'h14, mk_instr(5), 1'b0, 5, 1'b0, "dn5_end");

        // JR in RUN: neither output.
        cycle(32'h14, jr_instr, 1'b0, 0, 1'b0, "run_jr");

        // Random traffic concentrated on a few entries to hit saturation.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = {$urandom_range(0, 255) , 8'h0} | 32'($urandom_range(0, 7) << 2);
            cycle(pc, mk_instr(ops[$urandom_range(0, 10)]), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7), 1'($urandom_range(0, 1)), "rand");
        end

        // Reset mid-RUN: training lost, everything predicts not-taken again.
        do_reset("midrun");
        for (int i = 0; i < DEPTH; i++)
            cycle(32'($urandom), mk_instr(ops[$urandom_range(0, 10)]), 1'b1,
                  $urandom_range(0, DEPTH - 1), 1'b1, "reinit");
        for (int i = 0; i < DEPTH; i++)
            cycle(32'(i * 4), mk_instr(4), 1'b0, 0, 1'b0, "post_reset");

        // History sequence T,T,N on idx 9, then a BEQ at PC 0.
        cycle(32'h24, mk_instr(4), 1'b1, 9, 1'b1, "hist_t1");
        cycle(32'h24, mk_instr(4), 1'b1, 9, 1'b1, "hist_t2");
        cycle(32'h24, mk_instr(4), 1'b1, 9, 1'b0, "hist_n");
        cycle(32'h0,  mk_instr(4), 1'b0, 0, 1'b0, "hist_pc0");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bht_predictor.md
# bht_predictor

Parametrised branch predictor for the five-stage MIPS pipeline, replacing the single shared 2-bit counter with a table of per-index saturating counters. It predicts in the fetch stage: conditional branches from a table indexed by PC bits, and J/JAL as always taken. The table is trained by an update port driven from the branch-resolve stage. After reset, an internal FSM walks the whole table and initialises every entry before predictions are enabled.

## Interface
- IDX_W, 6: table index width; DEPTH = 2**IDX_W entries.
- CNT_W, 2: counter width, 2..4.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- fetch_pc  in  32  PC of the fetched instruction.
- fetch_instr  in  32  fetched instruction word.
- takebr  out  1  predict the conditional branch taken.
- takej  out  1  unconditional J/JAL jump.
- pred_idx  out  IDX_W  table index used for this prediction; pipelined alongside the instruction to the resolve stage.
- upd_valid  in  1  resolve stage reports one resolved conditional branch this cycle.
- upd_idx  in  IDX_W  pred_idx carried with that branch.
- upd_taken  in  1  actual outcome.
- ready  out  1  table initialised; predictions and updates active.

## Operation
- Decode uses opcode = instr[31:26].
  - Branch opcodes: 1 (BZ), 4, 5, 6, 7.
  - Jump opcodes: 2 (J), 3 (JAL).
  - JR and JALR (opcode 0) are never predicted.
- Index = fetch_pc[IDX_W+1:2]. Under BHT_GSHARE_EN, the index is XORed with the history register (see Configuration).
- takebr = ready & isbranch & counter[pred_idx][CNT_W-1]. The counter MSB set means taken.
- takej = isjump, independent of ready.
- Counter update on upd_valid & ready:
  - upd_taken = 1: increment, saturating at 2**CNT_W-1.
  - upd_taken = 0: decrement, saturating at 0.
- FSM states:
  - INIT: index counter walks 0 to DEPTH-1, writing INIT_VAL = 2**(CNT_W-1)-1 (weakly not-taken) into one entry per cycle. ready = 0. Updates are ignored.
  - RUN: entered after the write to entry DEPTH-1. ready = 1.
  - No other transitions exist except via rst.
- Reset values:
  - state = INIT, init index = 0, ready = 0, history = 0.
  - takebr = 0, since ready is 0.
  - Table contents are not reset directly; INIT overwrites them.
- Reset asserted mid-RUN or mid-INIT returns immediately to INIT at index 0. All training is lost.

## Timing
- Prediction is combinational from fetch_pc/fetch_instr and the registered table, in the same cycle with zero latency.
- An update written at posedge N is visible to predictions in cycle N+1.
- Same-cycle update and fetch to the same index: the prediction uses the pre-update value. There is no bypass.
- ready rises exactly DEPTH cycles after rst deasserts: 64 cycles at the default.
- At most one update per cycle. upd_valid during INIT is dropped with no side effects.

## Configuration
- BHT_GSHARE_EN defined:
  - Adds an IDX_W-bit global history register, reset 0.
  - On each accepted update, history <= {history[IDX_W-2:0], upd_taken}.
  - Index = fetch_pc[IDX_W+1:2] ^ history.
  - The update uses upd_idx as supplied, with no rehash.
- BHT_GSHARE_EN undefined:
  - No history register.
  - Index = fetch_pc[IDX_W+1:2].

## Structure
- Shared package bp_pkg holds:
  - opcode constants OP_BZ, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ;
  - the FSM state typedef (INIT, RUN);
  - a saturating-update function parameterised by CNT_W.
- One sub-module, bp_opdecode: combinational, fetch_instr to isbranch/isjump. It is reusable by the decode stage.

## Test plan
- Reset, then idle: ready = 0 for 64 cycles and 1 on cycle 64. A BEQ fetched after ready gives takebr = 0, since every entry reads 1.
- Fetch BEQ at PC 0x100 (idx 0) twice, preceded by two updates idx 0 taken: the counter goes 1→2→3, takebr = 1 after the first update. A third taken update holds at 3.
- From counter 3 at idx 5: apply 4 not-taken updates. Counter goes 2, 1, 0, 0. takebr drops to 0 after the second update.
- JAL (opcode 3) during INIT: takej = 1, takebr = 0. JR (funct 8) in RUN: both outputs 0. Update during INIT leaves entry at 1 after ready.
- Assert rst mid-RUN with trained entries: ready drops at once. After 64 cycles all entries read 1 (BEQ predicts not-taken).
- With BHT_GSHARE_EN: apply taken updates T,T,N, giving history = 3'b110 in the low bits. A BEQ at PC 0x0 then gets pred_idx = 6.
